// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLB maintenance sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
module tlb_maint_ctrl #(
    parameter int TLBNUM        = 16,
    parameter int TLBIDLEN      = 4,
    parameter int SRCH_MAX_WAIT = 4,
    parameter int ENTRY_W       = 89,
    parameter int ENTRY_E_BIT   = 36,
    parameter int RESULT_W      = 37
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [2:0]          op_code,
    input  logic [4:0]          op_inv_op,
    input  logic [9:0]          op_inv_asid,
    input  logic [31:0]         op_inv_va,
    input  logic [TLBIDLEN-1:0] csr_index,
    input  logic [18:0]         csr_vppn,
    input  logic [9:0]          csr_asid,
    input  logic [ENTRY_W-1:0]  csr_entry,
    input  logic                mem_s1_req,
    input  logic [18:0]         mem_s1_vppn,
    input  logic                mem_s1_va_bit12,
    input  logic [9:0]          mem_s1_asid,
    output logic                mem_s1_gnt,
    output logic [18:0]         tlb_s1_vppn,
    output logic                tlb_s1_va_bit12,
    output logic [9:0]          tlb_s1_asid,
    input  logic [RESULT_W-1:0] tlb_s1_result,
    output logic                tlb_we,
    output logic [TLBIDLEN-1:0] tlb_w_index,
    output logic [ENTRY_W-1:0]  tlb_w_entry,
    output logic [TLBIDLEN-1:0] tlb_r_index,
    input  logic [ENTRY_W-1:0]  tlb_r_entry,
    output logic                tlb_invtlb_valid,
    output logic [4:0]          tlb_invtlb_op,
    output logic [9:0]          tlb_invtlb_asid,
    output logic [31:0]         tlb_invtlb_va,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [TLBIDLEN-1:0] resp_index,
    output logic [ENTRY_W-1:0]  resp_entry,
    output logic                resp_ine,
    output logic                tlb_changed
);

    localparam int WAIT_W = $clog2(SRCH_MAX_WAIT + 1);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [TLBIDLEN-1:0]   idx_q, idx_d;
    logic [18:0]           vppn_q, vppn_d;
    logic [9:0]            asid_q, asid_d;
    logic [ENTRY_W-1:0]    entry_q, entry_d;
    logic [4:0]            inv_op_q, inv_op_d;
    logic [9:0]            inv_asid_q, inv_asid_d;
    logic [31:0]           inv_va_q, inv_va_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [TLBIDLEN-1:0]   fill_q, fill_d;
    logic                  chg_q, chg_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [TLBIDLEN-1:0]   resp_index_q, resp_index_d;
    logic [ENTRY_W-1:0]    resp_entry_q, resp_entry_d;
    logic                  resp_ine_q, resp_ine_d;
    logic                  srch_own;
    logic                  unused_result_bits;

    assign unused_result_bits = ^tlb_s1_result[RESULT_W-1:TLBIDLEN+1];

    // The search yields port 1 to the memory pipeline for a bounded number of cycles.
    assign srch_own = (state_q == S_SRCH) &&
                      !(mem_s1_req && (wait_q < WAIT_W'(SRCH_MAX_WAIT)));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vppn_d       = vppn_q;
        asid_d       = asid_q;
        entry_d      = entry_q;
        inv_op_d     = inv_op_q;
        inv_asid_d   = inv_asid_q;
        inv_va_d     = inv_va_q;
        wait_d       = wait_q;
        chg_d        = chg_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        resp_entry_d = resp_entry_q;
        resp_ine_d   = resp_ine_q;
        fill_d       = (fill_q == TLBIDLEN'(TLBNUM - 1)) ? '0 : fill_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    idx_d      = csr_index;
                    vppn_d     = csr_vppn;
                    asid_d     = csr_asid;
                    entry_d    = csr_entry;
                    inv_op_d   = op_inv_op;
                    inv_asid_d = op_inv_asid;
                    inv_va_d   = op_inv_va;
                    wait_d     = '0;
                    chg_d      = 1'b0;
                    case (op_code)
                        OP_SRCH: state_d = S_SRCH;
                        OP_RD:   state_d = S_RD;
                        OP_WR: begin
                            state_d = S_WR;
                            chg_d   = 1'b1;
                        end
                        OP_FILL: begin
                            idx_d   = fill_q;
                            state_d = S_WR;
                            chg_d   = 1'b1;
                        end
                        OP_INV: begin
                            if (op_inv_op > 5'd6) begin
                                resp_ine_d = 1'b1;
                                state_d    = S_RESP;
                            end else begin
                                chg_d   = 1'b1;
                                state_d = S_INV;
                            end
                        end
                        default: begin
                            resp_ine_d = 1'b0;
                            state_d    = S_RESP;
                        end
                    endcase
                end
            end
            S_SRCH: begin
                if (srch_own) begin
                    resp_hit_d   = tlb_s1_result[0];
                    resp_index_d = tlb_s1_result[TLBIDLEN:1];
                    resp_ine_d   = 1'b0;
                    state_d      = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RD: begin
                resp_entry_d = tlb_r_entry[ENTRY_E_BIT] ? tlb_r_entry : '0;
                resp_ine_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_WR, S_INV: begin
                resp_ine_d = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            vppn_q       <= '0;
            asid_q       <= '0;
            entry_q      <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_va_q     <= '0;
            wait_q       <= '0;
            fill_q       <= '0;
            chg_q        <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
            resp_ine_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vppn_q       <= vppn_d;
            asid_q       <= asid_d;
            entry_q      <= entry_d;
            inv_op_q     <= inv_op_d;
            inv_asid_q   <= inv_asid_d;
            inv_va_q     <= inv_va_d;
            wait_q       <= wait_d;
            fill_q       <= fill_d;
            chg_q        <= chg_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
            resp_entry_q <= resp_entry_d;
            resp_ine_q   <= resp_ine_d;
        end
    end

    assign op_ready        = (state_q == S_IDLE);
    assign mem_s1_gnt      = !srch_own;
    assign tlb_s1_vppn     = srch_own ? vppn_q : mem_s1_vppn;
    assign tlb_s1_va_bit12 = srch_own ? 1'b0   : mem_s1_va_bit12;
    assign tlb_s1_asid     = srch_own ? asid_q : mem_s1_asid;

    // Side-effect strobes are masked while reset is high so a reset landing mid-op never commits.
    assign tlb_we           = (state_q == S_WR) && !reset;
    assign tlb_w_index      = idx_q;
    assign tlb_w_entry      = entry_q;
    assign tlb_r_index      = idx_q;
    assign tlb_invtlb_valid = (state_q == S_INV) && !reset;
    assign tlb_invtlb_op    = inv_op_q;
    assign tlb_invtlb_asid  = inv_asid_q;
    assign tlb_invtlb_va    = inv_va_q;
    assign resp_valid       = (state_q == S_RESP) && !reset;
    assign tlb_changed      = (state_q == S_RESP) && chg_q && !reset;
    assign resp_hit         = resp_hit_q;
    assign resp_index       = resp_index_q;
    assign resp_entry       = resp_entry_q;
    assign resp_ine         = resp_ine_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - scoreboard bench for tlb_maint_ctrl with a behavioural TLB array
module tb_tlb_maint_ctrl;

    localparam int EW = 89;
    localparam int RW = 37;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [2:0]      op_code = '0;
    logic [4:0]      op_inv_op = '0;
    logic [9:0]      op_inv_asid = '0;
    logic [31:0]     op_inv_va = '0;
    logic [3:0]      csr_index = '0;
    logic [18:0]     csr_vppn = '0;
    logic [9:0]      csr_asid = '0;
    logic [EW-1:0]   csr_entry = '0;
    logic            mem_s1_req = 1'b0;
    logic [18:0]     mem_s1_vppn = '0;
    logic            mem_s1_va_bit12 = 1'b0;
    logic [9:0]      mem_s1_asid = '0;
    logic            mem_s1_gnt;
    logic [18:0]     tlb_s1_vppn;
    logic            tlb_s1_va_bit12;
    logic [9:0]      tlb_s1_asid;
    logic [RW-1:0]   tlb_s1_result;
    logic            tlb_we;
    logic [3:0]      tlb_w_index;
    logic [EW-1:0]   tlb_w_entry;
    logic [3:0]      tlb_r_index;
    logic [EW-1:0]   tlb_r_entry;
    logic            tlb_invtlb_valid;
    logic [4:0]      tlb_invtlb_op;
    logic [9:0]      tlb_invtlb_asid;
    logic [31:0]     tlb_invtlb_va;
    logic            resp_valid;
    logic            resp_hit;
    logic [3:0]      resp_index;
    logic [EW-1:0]   resp_entry;
    logic            resp_ine;
    logic            tlb_changed;

    tlb_maint_ctrl dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_inv_op(op_inv_op), .op_inv_asid(op_inv_asid), .op_inv_va(op_inv_va),
        .csr_index(csr_index), .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_entry(csr_entry),
        .mem_s1_req(mem_s1_req), .mem_s1_vppn(mem_s1_vppn), .mem_s1_va_bit12(mem_s1_va_bit12),
        .mem_s1_asid(mem_s1_asid), .mem_s1_gnt(mem_s1_gnt),
        .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
        .tlb_s1_result(tlb_s1_result),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
        .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
        .tlb_invtlb_asid(tlb_invtlb_asid), .tlb_invtlb_va(tlb_invtlb_va),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_index(resp_index),
        .resp_entry(resp_entry), .resp_ine(resp_ine), .tlb_changed(tlb_changed)
    );

    always #5 clk = ~clk;

    // Entry layout: vppn[18:0] ps[24:19] g[25] asid[35:26] e[36] ppn0[56:37] (rest zero here)
    function automatic logic [EW-1:0] mk_entry(input logic e, input logic [18:0] vppn,
                                               input logic [5:0] ps, input logic g,
                                               input logic [9:0] asid, input logic [19:0] ppn0);
        logic [EW-1:0] r;
        r        = '0;
        r[18:0]  = vppn;
        r[24:19] = ps;
        r[25]    = g;
        r[35:26] = asid;
        r[36]    = e;
        r[56:37] = ppn0;
        return r;
    endfunction

    function automatic logic inv_match(input logic [EW-1:0] en, input logic [4:0] op,
                                       input logic [9:0] asid, input logic [31:0] va);
        logic g, am, vm;
        g  = en[25];
        am = (en[35:26] == asid);
        vm = (en[18:0] == va[31:13]);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && am;
            5'd5:       return !g && am && vm;
            5'd6:       return (g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    logic [EW-1:0] tlb_mem [16] = '{default: '0};
    logic          s_found;
    logic [3:0]    s_idx;

    always_comb begin
        s_found = 1'b0;
        s_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (!s_found && tlb_mem[i][36] && tlb_mem[i][18:0] == tlb_s1_vppn &&
                (tlb_mem[i][25] || tlb_mem[i][35:26] == tlb_s1_asid)) begin
                s_found = 1'b1;
                s_idx   = 4'(i);
            end
        end
    end
    assign tlb_s1_result = {32'b0, s_idx, s_found};
    assign tlb_r_entry   = tlb_mem[tlb_r_index];

    always @(posedge clk) begin
        if (tlb_we) tlb_mem[tlb_w_index] <= tlb_w_entry;
        if (tlb_invtlb_valid)
            for (int i = 0; i < 16; i++)
                if (inv_match(tlb_mem[i], tlb_invtlb_op, tlb_invtlb_asid, tlb_invtlb_va))
                    tlb_mem[i][36] <= 1'b0;
    end

    int         cyc = 0;
    logic [3:0] fcnt = '0;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        fcnt <= reset ? 4'd0 : fcnt + 4'd1;
    end

    typedef struct { int cyc; logic hit; logic [3:0] idx; logic [EW-1:0] entry; logic ine; logic chg; } resp_t;
    typedef struct { int cyc; logic [3:0] idx; logic [EW-1:0] entry; } wr_t;
    typedef struct { int cyc; logic [4:0] op; logic [9:0] asid; logic [31:0] va; } inv_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    inv_t  inv_q[$];
    resp_t mr;
    wr_t   mw;
    inv_t  mi;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected response register contents, held until the next RESP.
    logic          e_hit = 1'b0;
    logic [3:0]    e_idx = '0;
    logic [EW-1:0] e_entry = '0;
    logic          e_ine = 1'b0;

    task automatic push_resp(input int c, input logic chg);
        resp_t r;
        r.cyc = c; r.hit = e_hit; r.idx = e_idx; r.entry = e_entry; r.ine = e_ine; r.chg = chg;
        resp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                mr = resp_q.pop_front();
                chk("resp_cycle", cyc, mr.cyc);
                chk("resp_hit", resp_hit, mr.hit);
                chk("resp_index", resp_index, mr.idx);
                chk("resp_entry", resp_entry, mr.entry);
                chk("resp_ine", resp_ine, mr.ine);
                chk("tlb_changed", tlb_changed, mr.chg);
            end
        end else if (tlb_changed) chk("changed_without_resp", 1, 0);
        if (tlb_we) begin
            chk("we_with_inv", tlb_invtlb_valid, 0);
            if (wr_q.size() == 0) chk("we_unexpected", 1, 0);
            else begin
                mw = wr_q.pop_front();
                chk("we_cycle", cyc, mw.cyc);
                chk("w_index", tlb_w_index, mw.idx);
                chk("w_entry", tlb_w_entry, mw.entry);
            end
        end
        if (tlb_invtlb_valid) begin
            if (inv_q.size() == 0) chk("inv_unexpected", 1, 0);
            else begin
                mi = inv_q.pop_front();
                chk("inv_cycle", cyc, mi.cyc);
                chk("inv_op", tlb_invtlb_op, mi.op);
                chk("inv_asid", tlb_invtlb_asid, mi.asid);
                chk("inv_va", tlb_invtlb_va, mi.va);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!op_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!op_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic [2:0] code, output int t);
        wait_ready();
        op_valid = 1'b1;
        op_code  = code;
        t        = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic op_wr(input logic [3:0] idx, input logic [EW-1:0] en);
        int t;
        wr_t w;
        csr_index = idx;
        csr_entry = en;
        drive(3'd2, t);
        w.cyc = t + 1; w.idx = idx; w.entry = en;
        wr_q.push_back(w);
        e_ine = 1'b0;
        push_resp(t + 2, 1'b1);
    endtask

    task automatic op_fill(input logic [EW-1:0] en, input logic [3:0] exp_idx);
        int t;
        wr_t w;
        csr_index = 4'd3;
        csr_entry = en;
        drive(3'd3, t);
        w.cyc = t + 1; w.idx = exp_idx; w.entry = en;
        wr_q.push_back(w);
        e_ine = 1'b0;
        push_resp(t + 2, 1'b1);
    endtask

    task automatic op_rd(input logic [3:0] idx, input logic [EW-1:0] exp_entry);
        int t;
        csr_index = idx;
        drive(3'd1, t);
        e_entry = exp_entry;
        e_ine   = 1'b0;
        push_resp(t + 2, 1'b0);
    endtask

    task automatic op_srch(input logic [18:0] vppn, input logic [9:0] asid,
                           input logic hit, input logic [3:0] idx, input int k);
        int t;
        csr_vppn = vppn;
        csr_asid = asid;
        drive(3'd0, t);
        e_hit = hit;
        e_idx = idx;
        e_ine = 1'b0;
        push_resp(t + 2 + k, 1'b0);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            chk("s1_gnt", mem_s1_gnt, (i < k));
            chk("s1_vppn", tlb_s1_vppn, (i < k) ? mem_s1_vppn : vppn);
        end
        @(posedge clk); #1;
    endtask

    task automatic op_inv(input logic [4:0] iop, input logic [9:0] iasid,
                          input logic [31:0] iva, input logic exp_ine);
        int t;
        inv_t v;
        op_inv_op   = iop;
        op_inv_asid = iasid;
        op_inv_va   = iva;
        drive(3'd4, t);
        e_ine = exp_ine;
        if (exp_ine) push_resp(t + 1, 1'b0);
        else begin
            v.cyc = t + 1; v.op = iop; v.asid = iasid; v.va = iva;
            inv_q.push_back(v);
            push_resp(t + 2, 1'b1);
        end
    endtask

    task automatic op_rsvd(input logic [2:0] code);
        int t;
        drive(code, t);
        e_ine = 1'b0;
        push_resp(t + 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [EW-1:0] ent_a, ent_f1, ent_f2, ent_r;

    initial begin
        int t;
        ent_a  = mk_entry(1'b1, 19'h12345, 6'd12, 1'b0, 10'd3, 20'hABCDE);
        ent_f1 = mk_entry(1'b1, 19'h00777, 6'd12, 1'b1, 10'd1, 20'h11111);
        ent_f2 = mk_entry(1'b1, 19'h00888, 6'd12, 1'b0, 10'd2, 20'h22222);
        ent_r  = mk_entry(1'b1, 19'h00999, 6'd12, 1'b0, 10'd4, 20'h33333);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_we", tlb_we, 0);
        chk("rst_inv", tlb_invtlb_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_resp_entry", resp_entry, 0);
        chk("rst_resp_ine", resp_ine, 0);
        chk("rst_changed", tlb_changed, 0);
        chk("rst_gnt", mem_s1_gnt, 1);

        op_wr(4'd5, ent_a);
        op_rd(4'd5, ent_a);

        mem_s1_vppn = 19'h0AAAA;
        mem_s1_asid = 10'd7;
        mem_s1_req  = 1'b1;
        op_srch(19'h12345, 10'd3, 1'b1, 4'd5, 4);
        mem_s1_req  = 1'b0;

        wait_ready();
        while (fcnt != 4'd15) begin
            @(posedge clk); #1;
        end
        op_fill(ent_f1, 4'd15);
        op_fill(ent_f2, 4'd2);

        op_inv(5'd5, 10'd3, 32'h2468A000, 1'b0);
        op_rd(4'd5, '0);
        op_inv(5'd7, 10'd3, 32'h0, 1'b1);
        op_rsvd(3'd6);

        op_srch(19'h00777, 10'd9, 1'b1, 4'd15, 0);
        op_srch(19'h12345, 10'd3, 1'b0, 4'd0, 0);
        op_rd(4'd2, ent_f2);

        // Reset lands while the write is in its WR cycle.
        csr_index = 4'd9;
        csr_entry = ent_r;
        drive(3'd2, t);
        reset = 1'b1;
        @(negedge clk);
        chk("we_during_reset", tlb_we, 0);
        chk("resp_valid_during_reset", resp_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ready_after_reset", op_ready, 1);
        e_hit = 1'b0; e_idx = '0; e_entry = '0; e_ine = 1'b0;
        op_rd(4'd9, '0);
        op_rd(4'd15, ent_f1);

        repeat (6) @(posedge clk);
        #1;
        chk("resp_queue_empty", resp_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("inv_queue_empty", inv_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
